// File: rtl/bnn_fc_layer_if.sv
// bnn_fc_layer_if
//   Bundles the image-side handshake, the weight-memory port, the downstream
//   handshake and (optionally) the threshold-memory port of bnn_fc_layer.
//   Optional feature macro: BNN_THRESH_MEM_EN adds th_addr/th_data.
// Modports:
//   master : the layer side (drives img_req, w_addr, rcv_ack, outputs, th_addr)
//   slave  : the environment side (image register, weight/threshold memories,
//            downstream stage)
interface bnn_fc_layer_if #(
  parameter int INPUT_NUM  = 784,
  parameter int WORD_W     = 16,
  parameter int NEURON_NUM = 128,
  parameter int AW         = 13,
  parameter int CW         = 10
);
  logic                  img_req;
  logic                  img_ack;
  logic [INPUT_NUM-1:0]  image;
  logic [AW-1:0]         w_addr;
  logic [WORD_W-1:0]     w_data;
  logic                  rcv_req;
  logic                  rcv_ack;
  logic [NEURON_NUM-1:0] outputs;
`ifdef BNN_THRESH_MEM_EN
  logic [$clog2(NEURON_NUM)-1:0] th_addr;
  logic [CW-1:0]                 th_data;
`endif

  modport master (
    output img_req,
    input  img_ack,
    input  image,
    output w_addr,
    input  w_data,
    input  rcv_req,
    output rcv_ack,
    output outputs
`ifdef BNN_THRESH_MEM_EN
    ,
    output th_addr,
    input  th_data
`endif
  );

  modport slave (
    input  img_req,
    output img_ack,
    output image,
    input  w_addr,
    output w_data,
    output rcv_req,
    input  rcv_ack,
    input  outputs
`ifdef BNN_THRESH_MEM_EN
    ,
    input  th_addr,
    output th_data
`endif
  );
endinterface

// File: rtl/bnn_fc_layer.sv
// bnn_fc_layer
//   Binary fully-connected hidden layer. Pulls one binarized image over a
//   4-phase req/ack handshake, computes NEURON_NUM activations by
//   XNOR-popcount against weights streamed WORD_W bits per cycle from an
//   external memory (1-cycle read latency), then offers the activation vector
//   downstream over a 4-phase handshake.
//   Optional feature macro: BNN_THRESH_MEM_EN -- per-neuron thresholds are read
//   from an external memory (th_addr/th_data) instead of parameter THRESH.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : bnn_fc_layer_if.master
//          img_req/img_ack/image    image-register handshake
//          w_addr/w_data            weight memory (addr = n*CHUNKS + c)
//          rcv_req/rcv_ack/outputs  downstream handshake and activations
//          th_addr/th_data          threshold memory (BNN_THRESH_MEM_EN only)
module bnn_fc_layer #(
  parameter int INPUT_NUM  = 784,
  parameter int WORD_W     = 16,
  parameter int NEURON_NUM = 128,
  parameter int AW         = 13,
  parameter int CW         = 10,
  parameter int THRESH     = 392
) (
  input logic            clk,
  input logic            rst,
  bnn_fc_layer_if.master bus
);
  localparam int CHUNKS = INPUT_NUM / WORD_W;
  localparam int NW     = $clog2(NEURON_NUM);
  localparam int CHW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [NW-1:0]  N_LAST = NW'(NEURON_NUM - 1);
  localparam logic [CHW-1:0] C_LAST = CHW'(CHUNKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACKWAIT,
    ST_CALC,
    ST_DONE,
    ST_SND
  } state_t;

  state_t state_q, state_d;

  logic [INPUT_NUM-1:0]  img_buf_q, img_buf_d;
  logic [NW-1:0]         n_q, n_d;
  logic [CHW-1:0]        c_q, c_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  issue_done_q, issue_done_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  last_p1_q, last_p1_d;
  logic [NW-1:0]         n_p1_q, n_p1_d;
  logic [CHW-1:0]        c_p1_q, c_p1_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [NEURON_NUM-1:0] out_q, out_d;

  logic                  issue_en;
  logic [WORD_W-1:0]     img_word;
  logic [CW-1:0]         sum;
  logic [CW-1:0]         thresh;
  logic                  fire;
  logic                  pass_end;

  function automatic logic [CW-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.img_ack)  state_d = ST_ACKWAIT;
      ST_ACKWAIT: if (!bus.img_ack) state_d = ST_CALC;
      ST_CALC:    if (pass_end)     state_d = ST_DONE;
      ST_DONE:    if (bus.rcv_req)  state_d = ST_SND;
      ST_SND:     if (!bus.rcv_req) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes
  always_comb begin
    bus.img_req = (state_q == ST_IDLE);
    bus.rcv_ack = (state_q == ST_SND);
  end

  // Stage p0: address issue; stage p1: returning weight word
  always_comb begin
    issue_en = (state_q == ST_CALC) && !issue_done_q;
    img_word = img_buf_q[int'(c_p1_q)*WORD_W +: WORD_W];
    sum      = acc_q + popcount(~(img_word ^ bus.w_data));
`ifdef BNN_THRESH_MEM_EN
    thresh   = bus.th_data;
`else
    thresh   = CW'(THRESH);
`endif
    fire     = (sum >= thresh);
    pass_end = vld_p1_q && last_p1_q && (n_p1_q == N_LAST);

    img_buf_d = img_buf_q;
    if ((state_q == ST_IDLE) && bus.img_ack) begin
      img_buf_d = bus.image;
    end

    // Counters sit at zero outside CALC so every pass starts from n=0, c=0.
    n_d          = n_q;
    c_d          = c_q;
    addr_d       = addr_q;
    issue_done_d = issue_done_q;
    if (state_q != ST_CALC) begin
      n_d          = '0;
      c_d          = '0;
      addr_d       = '0;
      issue_done_d = 1'b0;
    end else if (issue_en) begin
      if ((c_q == C_LAST) && (n_q == N_LAST)) begin
        issue_done_d = 1'b1;
      end else begin
        // n*CHUNKS+c is sequential, so the address is a plain incrementer.
        addr_d = addr_q + AW'(1);
        if (c_q == C_LAST) begin
          c_d = '0;
          n_d = n_q + NW'(1);
        end else begin
          c_d = c_q + CHW'(1);
        end
      end
    end

    vld_p1_d  = issue_en;
    last_p1_d = issue_en && (c_q == C_LAST);
    n_p1_d    = n_q;
    c_p1_d    = c_q;

    acc_d = acc_q;
    if (state_q != ST_CALC) begin
      acc_d = '0;
    end else if (vld_p1_q) begin
      acc_d = last_p1_q ? '0 : sum;
    end

    out_d = out_q;
    if (vld_p1_q && last_p1_q) begin
      out_d[n_p1_q] = fire;
    end
  end

  always_comb begin
    bus.w_addr  = addr_q;
    bus.outputs = out_q;
`ifdef BNN_THRESH_MEM_EN
    bus.th_addr = n_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q          <= '0;
      c_q          <= '0;
      addr_q       <= '0;
      issue_done_q <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      acc_q        <= '0;
      out_q        <= '0;
    end else begin
      n_q          <= n_d;
      c_q          <= c_d;
      addr_q       <= addr_d;
      issue_done_q <= issue_done_d;
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
    end
  end

  // Data-only registers: qualified by vld_p1_q / state, so no reset needed
  always_ff @(posedge clk) begin
    img_buf_q <= img_buf_d;
    n_p1_q    <= n_p1_d;
    c_p1_q    <= c_p1_d;
  end
endmodule

// File: tb/tb_bnn_fc_layer.sv
module tb_bnn_fc_layer;
  localparam int INPUT_NUM   = 784;
  localparam int WORD_W      = 16;
  localparam int NEURON_NUM  = 128;
  localparam int AW          = 13;
  localparam int CW          = 10;
  localparam int THRESH      = 392;
  localparam int CHUNKS      = INPUT_NUM / WORD_W;
  localparam int DEPTH       = NEURON_NUM * CHUNKS;
  localparam int CALC_CYCLES = DEPTH + 1;
  localparam int OW          = NEURON_NUM;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_fc_layer_if #(
    .INPUT_NUM(INPUT_NUM), .WORD_W(WORD_W), .NEURON_NUM(NEURON_NUM), .AW(AW), .CW(CW)
  ) bus ();

  bnn_fc_layer #(
    .INPUT_NUM(INPUT_NUM), .WORD_W(WORD_W), .NEURON_NUM(NEURON_NUM), .AW(AW), .CW(CW),
    .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External memories, 1-cycle read latency
  logic [WORD_W-1:0] wmem [2**AW];
  int                thr  [NEURON_NUM];
  always @(posedge clk) bus.w_data <= wmem[bus.w_addr];
`ifdef BNN_THRESH_MEM_EN
  always @(posedge clk) bus.th_data <= CW'(thr[bus.th_addr]);
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_out = '0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: neuron n fires when the XNOR match count of the whole image
  // against its full weight vector reaches its threshold.
  function automatic logic [OW-1:0] model(input logic [INPUT_NUM-1:0] img);
    logic [OW-1:0]        r;
    logic [INPUT_NUM-1:0] wv;
    for (int n = 0; n < NEURON_NUM; n++) begin
      for (int c = 0; c < CHUNKS; c++) wv[c*WORD_W +: WORD_W] = wmem[n*CHUNKS + c];
      r[n] = ($countones(~(img ^ wv)) >= thr[n]);
    end
    return r;
  endfunction

  // Whenever the result is offered downstream it must match the model
  always @(negedge clk) begin
    if (!rst && bus.rcv_ack === 1'b1) check("outputs_on_ack", bus.outputs, exp_out);
  end

  task automatic fill_w_const(input logic [WORD_W-1:0] v);
    for (int a = 0; a < 2**AW; a++) wmem[a] = v;
  endtask

  task automatic fill_w_rand();
    for (int a = 0; a < 2**AW; a++) wmem[a] = WORD_W'($urandom);
  endtask

  function automatic logic [INPUT_NUM-1:0] rand_img();
    logic [INPUT_NUM-1:0] v;
    for (int i = 0; i < INPUT_NUM; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic wait_img_req();
    int k = 0;
    while (bus.img_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("img_req_wait", OW'(bus.img_req), OW'(1));
  endtask

  // Image handshake; on return the next posedge is the ACKWAIT->CALC edge.
  task automatic start_pass(input logic [INPUT_NUM-1:0] img, input int hold_ack);
    wait_img_req();
    bus.image   = img;
    bus.img_ack = 1'b1;
    exp_out     = model(img);
    @(negedge clk);
    check("img_req_drop", OW'(bus.img_req), OW'(0));
    for (int i = 0; i < hold_ack; i++) begin
      bus.image = ~img;   // a re-capture would corrupt the result
      @(negedge clk);
      check("img_req_hold", OW'(bus.img_req), OW'(0));
    end
    bus.img_ack = 1'b0;
  endtask

  task automatic run_pass(input logic [INPUT_NUM-1:0] img, input int hold_ack,
                          input bit pre_req, output int calc_edges);
    int cnt = 0;
    start_pass(img, hold_ack);
    if (pre_req) begin
      bus.rcv_req = 1'b1;
      do begin
        @(posedge clk);
        #1;
        cnt++;
      end while (bus.rcv_ack !== 1'b1 && cnt < CALC_CYCLES + 50);
      @(negedge clk);
    end else begin
      repeat (CALC_CYCLES + 5) @(negedge clk);
      check("rcv_ack_early", OW'(bus.rcv_ack), OW'(0));
      bus.rcv_req = 1'b1;
      @(posedge clk);
      #1;
      check("rcv_ack_1cyc", OW'(bus.rcv_ack), OW'(1));
      @(negedge clk);
    end
    calc_edges = cnt;
    @(negedge clk);
    bus.rcv_req = 1'b0;
    @(posedge clk);
    #1;
    check("rcv_ack_fall", OW'(bus.rcv_ack), OW'(0));
    check("back_to_idle", OW'(bus.img_req), OW'(1));
    @(negedge clk);
  endtask

  initial begin
    int edges;
    logic [INPUT_NUM-1:0] img;

    for (int n = 0; n < NEURON_NUM; n++) thr[n] = THRESH;
    fill_w_const('1);
    rst         = 1'b1;
    bus.img_ack = 1'b0;
    bus.rcv_req = 1'b0;
    bus.image   = '0;

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_img_req", OW'(bus.img_req), OW'(1));
    check("rst_rcv_ack", OW'(bus.rcv_ack), OW'(0));
    check("rst_outputs", bus.outputs, '0);
    check("rst_w_addr", OW'(bus.w_addr), OW'(0));
    @(negedge clk);
    rst = 1'b0;

    // All-ones image and weights, downstream already requesting
    run_pass({INPUT_NUM{1'b1}}, 0, 1'b1, edges);
    check("calc_latency", OW'(edges), OW'(CALC_CYCLES + 2));
    check("allones_lit", bus.outputs, {OW{1'b1}});

    // All-zero weights
    fill_w_const('0);
    run_pass({INPUT_NUM{1'b1}}, 0, 1'b1, edges);
    check("allzero_w_lit", bus.outputs, '0);

    // Checkerboard image against matching weights
    fill_w_const(16'hAAAA);
    run_pass({CHUNKS{16'hAAAA}}, 0, 1'b1, edges);
    check("checker_lit", bus.outputs, {OW{1'b1}});

    // Threshold boundary: 392 / 391 / 784 matches
    fill_w_rand();
    for (int c = 0; c < CHUNKS; c++) begin
      wmem[0*CHUNKS + c] = (c < 24) ? 16'hFFFF : (c == 24) ? 16'h00FF : 16'h0000;
      wmem[1*CHUNKS + c] = (c < 24) ? 16'hFFFF : (c == 24) ? 16'h007F : 16'h0000;
      wmem[2*CHUNKS + c] = 16'hFFFF;
    end
    run_pass({INPUT_NUM{1'b1}}, 0, 1'b1, edges);
    check("bound_bits_lit", OW'(bus.outputs[2:0]), OW'(3'b101));

    // Random image/weights with img_ack held high for 10 extra cycles
    fill_w_rand();
    run_pass(rand_img(), 10, 1'b1, edges);

    // Random, downstream requests late
    fill_w_rand();
    run_pass(rand_img(), 0, 1'b0, edges);

    // Reset mid-CALC discards the pass
    fill_w_rand();
    img = rand_img();
    start_pass(img, 0);
    repeat (3000) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_img_req", OW'(bus.img_req), OW'(1));
    check("midrst_rcv_ack", OW'(bus.rcv_ack), OW'(0));
    check("midrst_outputs", bus.outputs, '0);
    check("midrst_w_addr", OW'(bus.w_addr), OW'(0));
    @(negedge clk);
    rst = 1'b0;
    run_pass(img, 0, 1'b1, edges);
    check("post_rst_latency", OW'(edges), OW'(CALC_CYCLES + 2));

`ifdef BNN_THRESH_MEM_EN
    // Per-neuron thresholds: even neurons unreachable, odd neurons always fire
    for (int n = 0; n < NEURON_NUM; n++) thr[n] = (n % 2 == 0) ? 785 : 0;
    fill_w_const('1);
    run_pass({INPUT_NUM{1'b1}}, 0, 1'b1, edges);
    check("thmem_lit", bus.outputs, {(OW/2){2'b10}});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
